lab3_qsys_debug_scan_master: RTL
================================

LAB3_QSYS_DEBUG_SCAN_MASTER -- requirements
Module: lab3_qsys_debug_scan_master

Interface
REQ-001 SHALL have parameters: DR_WIDTH, 38, debug data-register length; IR_WIDTH, 2, virtual IR length; TCK_DIV, 2, clk cycles per tck half-period (>=1).
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 cmd_valid  in  1  scan request.
REQ-006 cmd_ready  out  1  high only in IDLE; handshake = cmd_valid & cmd_ready.
REQ-007 cmd_ir  in  IR_WIDTH  virtual IR value for this scan.
REQ-008 cmd_dr  in  DR_WIDTH  data shifted into the debug slave.
REQ-009 rsp_valid  out  1  one-cycle pulse: scan complete.
REQ-010 rsp_dr  out  DR_WIDTH  data captured from vj_tdo; held until next completion.
REQ-011 vj_tck  out  1  generated virtual JTAG clock.
REQ-012 vj_tdi  out  1  serial data to slave.
REQ-013 vj_tdo  in  1  serial data from slave.
REQ-014 vj_ir_in  out  IR_WIDTH  virtual IR presented to slave.
REQ-015 vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti  out  1 each  virtual state strobes.

Function
REQ-016 FSM states: IDLE, UIR, CDR, SDR, UDR, RTI, DONE; exactly one of vj_uir/cdr/sdr/udr/rti high in the matching state, all low in IDLE/DONE.
REQ-017 Handshake in IDLE: latch cmd_ir, cmd_dr into shift register; next state UIR. cmd_valid outside IDLE is ignored, no command lost or queued.
REQ-018 tck period = 2*TCK_DIV clk cycles: first TCK_DIV cycles low, next TCK_DIV high; vj_tck low in IDLE/DONE; every period starts low.
REQ-019 UIR, CDR, UDR, RTI each last exactly one tck period; SDR lasts exactly DR_WIDTH tck periods.
REQ-020 vj_ir_in loads cmd_ir on entry to UIR and holds it through IDLE until next UIR.
REQ-021 SDR: shift LSB first; vj_tdi for bit i valid for the whole i-th SDR period (changes only while tck low); vj_tdi = 0 outside SDR.
REQ-022 vj_tdo sampled on the clk cycle where vj_tck goes high, only in SDR; sample i becomes rsp_dr bit i.
REQ-023 Latency: rsp_valid asserts exactly (DR_WIDTH+4)*2*TCK_DIV + 1 clk cycles after the handshake cycle (169 at defaults); rsp_dr updates that same cycle.
REQ-024 DONE lasts one cycle, then IDLE; cmd_ready high the cycle after rsp_valid.
REQ-025 Back-to-back: a command presented in the first IDLE cycle is accepted; no idle tck periods inserted beyond the FSM sequence.
REQ-026 No combinational path from any input to any output; all outputs registered.

Reset
REQ-027 On reset assertion, immediately: state IDLE, vj_tck 0, vj_tdi 0, all strobes 0, vj_ir_in 0, rsp_valid 0, rsp_dr 0, cmd_ready 0 while reset high.
REQ-028 Reset mid-scan aborts with no rsp_valid; cmd_ready 1 on first clk edge after reset deassertion.
REQ-029 vj_ir_out is unused by function; SHALL not affect any output.

Verification
REQ-030 Loopback vj_tdo=vj_tdi, cmd_dr=38'h2A_5555_AAAA, cmd_ir=2'b01 -> rsp_dr=38'h2A_5555_AAAA, vj_ir_in=2'b01 after completion.
REQ-031 vj_tdo tied 1, cmd_dr=0 -> rsp_dr all ones; vj_tdi 0 throughout.
REQ-032 Defaults: count clk from handshake to rsp_valid -> 169; vj_sdr high for exactly 152 cycles; 38 tck rising edges during SDR.
REQ-033 Reset asserted during SDR bit 10 -> all outputs at reset values same cycle, no rsp_valid; new scan afterwards completes correctly.
REQ-034 cmd_valid held high continuously for two commands -> second accepted the cycle after the first rsp_valid; commands presented while busy produce no extra scan.
REQ-035 TCK_DIV=1 build, loopback 38'h3F_FFFF_FFFE -> rsp_dr matches, latency 85 cycles.

Source files
------------

// File: rtl/lab3_qsys_debug_scan_master.sv
// Virtual-JTAG scan master: one command walks UIR, CDR, SDR, UDR, RTI on a
// divided tck and returns the DR word captured from vj_tdo.
module lab3_qsys_debug_scan_master #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2,
   parameter int TCK_DIV  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic                vj_tck,
   output logic                vj_tdi,
   input  logic                vj_tdo,
   output logic [IR_WIDTH-1:0] vj_ir_in,
   output logic                vj_uir,
   output logic                vj_cdr,
   output logic                vj_sdr,
   output logic                vj_udr,
   output logic                vj_rti
);

   typedef enum logic [2:0] {
      IDLE, UIR, CDR, SDR, UDR, RTI, DONE
   } state_t;

   localparam int PH_W  = (2*TCK_DIV > 2) ? $clog2(2*TCK_DIV) : 1;
   localparam int BIT_W = (DR_WIDTH > 2) ? $clog2(DR_WIDTH) : 1;

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2*TCK_DIV-1);
   localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(TCK_DIV-1);
   localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(TCK_DIV);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH-1);

   state_t              state_q, state_d;
   logic [PH_W-1:0]     ph_q, ph_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DR_WIDTH-1:0] shift_q, shift_d;
   logic [DR_WIDTH-1:0] cap_q, cap_d;
   logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                ready_q, ready_d;
   logic                tck_q, tck_d;
   logic                tdi_q, tdi_d;
   logic                uir_q, uir_d;
   logic                cdr_q, cdr_d;
   logic                sdr_q, sdr_d;
   logic                udr_q, udr_d;
   logic                rti_q, rti_d;
   logic                period_end;
   logic                active_d;
   logic [PH_W-1:0]     ph_inc;

   assign period_end = (ph_q == PH_LAST);
   assign ph_inc     = period_end ? '0 : ph_q + PH_W'(1);

   always_comb begin
      state_d     = state_q;
      ph_d        = ph_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      cap_d       = cap_q;
      ir_d        = ir_q;
      rsp_dr_d    = rsp_dr_q;
      rsp_valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && ready_q) begin
               state_d = UIR;
               ph_d    = '0;
               bit_d   = '0;
               shift_d = cmd_dr;
               ir_d    = cmd_ir;
            end
         end
         UIR: begin
            ph_d = ph_inc;
            if (period_end) state_d = CDR;
         end
         CDR: begin
            ph_d = ph_inc;
            if (period_end) begin
               state_d = SDR;
               bit_d   = '0;
            end
         end
         SDR: begin
            ph_d = ph_inc;
            // tdo is taken on the edge that raises tck
            if (ph_q == PH_RISE) begin
               cap_d = {vj_tdo, cap_q[DR_WIDTH-1:1]};
            end
            if (period_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) state_d = UDR;
               else bit_d = bit_q + BIT_W'(1);
            end
         end
         UDR: begin
            ph_d = ph_inc;
            if (period_end) state_d = RTI;
         end
         RTI: begin
            ph_d = ph_inc;
            if (period_end) begin
               state_d     = DONE;
               rsp_valid_d = 1'b1;
               rsp_dr_d    = cap_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from next-state values so they line up with state_q
   always_comb begin
      active_d = (state_d == UIR) || (state_d == CDR) || (state_d == SDR) ||
                 (state_d == UDR) || (state_d == RTI);
      tck_d    = active_d && (ph_d >= PH_HIGH);
      tdi_d    = (state_d == SDR) ? shift_d[0] : 1'b0;
      ready_d  = (state_d == IDLE);
      uir_d    = (state_d == UIR);
      cdr_d    = (state_d == CDR);
      sdr_d    = (state_d == SDR);
      udr_d    = (state_d == UDR);
      rti_d    = (state_d == RTI);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ph_q        <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         cap_q       <= '0;
         rsp_dr_q    <= '0;
         ir_q        <= '0;
         rsp_valid_q <= 1'b0;
         ready_q     <= 1'b0;
         tck_q       <= 1'b0;
         tdi_q       <= 1'b0;
         uir_q       <= 1'b0;
         cdr_q       <= 1'b0;
         sdr_q       <= 1'b0;
         udr_q       <= 1'b0;
         rti_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         cap_q       <= cap_d;
         rsp_dr_q    <= rsp_dr_d;
         ir_q        <= ir_d;
         rsp_valid_q <= rsp_valid_d;
         ready_q     <= ready_d;
         tck_q       <= tck_d;
         tdi_q       <= tdi_d;
         uir_q       <= uir_d;
         cdr_q       <= cdr_d;
         sdr_q       <= sdr_d;
         udr_q       <= udr_d;
         rti_q       <= rti_d;
      end
   end

   assign cmd_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dr    = rsp_dr_q;
   assign vj_tck    = tck_q;
   assign vj_tdi    = tdi_q;
   assign vj_ir_in  = ir_q;
   assign vj_uir    = uir_q;
   assign vj_cdr    = cdr_q;
   assign vj_sdr    = sdr_q;
   assign vj_udr    = udr_q;
   assign vj_rti    = rti_q;

endmodule
